// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// small elaboration-time helpers for baud timing and counter sizing.
package uart_pkg;

   // Receiver FSM states; PARITY is only visited when parity is compiled in.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_state_e;

   // Number of system clocks per serial bit (integer division).
   function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   // Bits needed for a counter that must hold every value 0..max_value.
   function automatic int counter_width(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. Resets to RESET_VAL
// so that an idle-high line does not look like activity coming out of reset.
module uart_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // The chain simply shifts the raw input through two stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser registers, forced to the line's idle level on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver presenting bytes on a valid/ready stream, with start-bit
// glitch rejection, framing/overrun detection and a saturating accepted-byte
// counter with a sticky done flag.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_stream
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ     = 100000000,
   parameter int BAUD_RATE      = 115200,
   parameter int DATA_BITS      = 8,
   parameter int EXPECTED_BYTES = 65536,
`ifdef UART_RX_PARITY_EN
   parameter int COUNT_W        = 32,
   parameter bit PARITY_ODD     = 1'b0
`else
   parameter int COUNT_W        = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy,
   output logic [COUNT_W-1:0]   byte_count,
   output logic                 done
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int CNT_W        = counter_width(CLKS_PER_BIT - 1);
   localparam int IDX_W        = counter_width(DATA_BITS);
   localparam logic [CNT_W-1:0]   BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX   = COUNT_W'(EXPECTED_BYTES);

   logic rx_s;

   uart_state_e            state_q, state_d;
   logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic                   done_q, done_d;
   logic                   frame_good;
   logic                   handshake;
`ifdef UART_RX_PARITY_EN
   logic                   parity_bad_q, parity_bad_d;
   logic                   parity_err_q, parity_err_d;
`endif

   uart_sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM: times each bit from the start edge and samples at bit centres.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_good  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_d = parity_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               baud_cnt_d = HALF_RELOAD;
               state_d    = START;
            end
         end
         START: begin
            if (baud_cnt_q == '0) begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  baud_cnt_d = BIT_RELOAD;
                  bit_idx_d  = '0;
                  state_d    = DATA;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt_q == '0) begin
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (bit_idx_q == IDX_W'(i)) shift_d[i] = rx_s;
               end
               baud_cnt_d = BIT_RELOAD;
               bit_idx_d  = bit_idx_q + 1'b1;
               if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_cnt_q == '0) begin
               parity_bad_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
               baud_cnt_d   = BIT_RELOAD;
               state_d      = STOP;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_cnt_q == '0) begin
               state_d = rx_s ? IDLE : WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
               if (parity_bad_q) begin
                  parity_err_d = 1'b1;
               end else
`endif
               if (!rx_s) begin
                  frame_err_d = 1'b1;
               end else begin
                  frame_good = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output stream: hold a word until consumed, flag overruns, count handshakes.
   always_comb begin
      handshake = valid_q & m_ready;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      count_d   = count_q;
      if (handshake) valid_d = 1'b0;
      if (frame_good) begin
         if (valid_q && !handshake) begin
            overrun_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end
      if (handshake && (count_q != COUNT_MAX)) count_d = count_q + 1'b1;
      done_d = done_q | (count_d == COUNT_MAX);
   end

   // State register with synchronous reset; reset aborts any frame silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity verdict is carried to the stop bit, where the error is reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         parity_bad_q <= parity_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign m_data      = data_q;
   assign m_valid     = valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
   assign busy        = (state_q != IDLE);
   assign byte_count  = count_q;
   assign done        = done_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: directed scenarios followed by
// randomized frames, all compared against a frame-level reference model.
module tb_uart_rx_stream;

   localparam int CF  = 1000000;
   localparam int BR  = 100000;
   localparam int CPB = CF / BR;
   localparam int EXP = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        frame_err;
   logic        parity_err;
   logic        overrun_err;
   logic        busy;
   logic [31:0] byte_count;
   logic        done;

   int checks = 0;
   int errors = 0;

   // Observed activity, accumulated by the monitor.
   int         frameErrSeen = 0;
   int         parityErrSeen = 0;
   int         overrunSeen = 0;
   int         validCycles = 0;
   int         stabilityErr = 0;
   logic [7:0] gotQ[$];
   logic       prevHold = 1'b0;
   logic [7:0] prevData = 8'h00;

   // Reference model state, at the level of whole frames and handshakes.
   int         frameErrExp = 0;
   int         parityErrExp = 0;
   int         overrunExp = 0;
   logic [7:0] expQ[$];
   bit         modelHeld = 1'b0;
   logic [7:0] modelData = 8'h00;
   int         modelCount = 0;
   bit         modelDone = 1'b0;

   uart_rx_stream #(
      .CLOCK_FREQ     (CF),
      .BAUD_RATE      (BR),
      .DATA_BITS      (8),
      .EXPECTED_BYTES (EXP),
      .COUNT_W        (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun_err (overrun_err),
      .busy        (busy),
      .byte_count  (byte_count),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Monitor on the falling edge: count pulses, log handshakes, check hold stability.
   always @(negedge clk) begin
      if (!rst) begin
         frameErrSeen  += int'(frame_err);
         parityErrSeen += int'(parity_err);
         overrunSeen   += int'(overrun_err);
         if (m_valid) validCycles++;
         if (m_valid && m_ready) gotQ.push_back(m_data);
         if (prevHold && m_valid && (m_data != prevData)) stabilityErr++;
      end
      prevHold = m_valid && !m_ready && !rst;
      prevData = m_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void modelAccept(input logic [7:0] d);
      expQ.push_back(d);
      if (modelCount < EXP) modelCount++;
      if (modelCount == EXP) modelDone = 1'b1;
   endfunction

   function automatic void modelReset();
      modelHeld  = 1'b0;
      modelCount = 0;
      modelDone  = 1'b0;
   endfunction

   task automatic setReady(input bit r);
      if (r && modelHeld) begin
         modelAccept(modelData);
         modelHeld = 1'b0;
      end
      m_ready = r;
      waitClocks(2);
   endtask

   // Send one frame, then update the model with what the frame should cause.
   task automatic applyStimulus(input logic [7:0] d, input bit stopOk, input bit parityOk);
      bit parityBad;
      parityBad = 1'b0;
      rx = 1'b0;
      waitClocks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         waitClocks(CPB);
      end
`ifdef UART_RX_PARITY_EN
      parityBad = !parityOk;
      rx = (^d) ^ parityBad;
      waitClocks(CPB);
`endif
      rx = stopOk;
      waitClocks(CPB);
      if (!stopOk) waitClocks(20);
      rx = 1'b1;
      waitClocks(CPB);
      if (parityBad) parityErrExp++;
      else if (!stopOk) frameErrExp++;
      else if (modelHeld) overrunExp++;
      else if (m_ready) modelAccept(d);
      else begin
         modelHeld = 1'b1;
         modelData = d;
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_frame_err"}, frameErrSeen, frameErrExp);
      checkOutput({tag, "_parity_err"}, parityErrSeen, parityErrExp);
      checkOutput({tag, "_overrun"}, overrunSeen, overrunExp);
      checkOutput({tag, "_nwords"}, gotQ.size(), expQ.size());
      while (gotQ.size() > 0 && expQ.size() > 0)
         checkOutput({tag, "_word"}, gotQ.pop_front(), expQ.pop_front());
      gotQ.delete();
      expQ.delete();
      checkOutput({tag, "_byte_count"}, byte_count, modelCount);
      checkOutput({tag, "_done"}, done, modelDone);
      checkOutput({tag, "_m_valid"}, m_valid, modelHeld);
      if (modelHeld) checkOutput({tag, "_m_data"}, m_data, modelData);
      checkOutput({tag, "_stable"}, stabilityErr, 0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      waitClocks(3);
      rst = 1'b0;
      modelReset();
      waitClocks(2);
   endtask

   initial begin
      int vcBefore;
      logic [7:0] d;
      rst = 1'b1;
      rx = 1'b1;
      m_ready = 1'b0;
      waitClocks(3);
      checkOutput("reset_m_valid", m_valid, 0);
      checkOutput("reset_m_data", m_data, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_byte_count", byte_count, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_errs", {frame_err, parity_err, overrun_err}, 0);
      rst = 1'b0;
      waitClocks(3);

      // Nominal frame with the consumer always ready.
      setReady(1'b1);
      vcBefore = validCycles;
      applyStimulus(8'hA5, 1'b1, 1'b1);
      checkOutput("nominal_valid_cycles", validCycles - vcBefore, 1);
      checkState("nominal");

      // Short low pulse on the line must be rejected as a glitch.
      rx = 1'b0;
      waitClocks(3);
      rx = 1'b1;
      waitClocks(2);
      checkOutput("glitch_busy_high", busy, 1);
      waitClocks(10);
      checkOutput("glitch_busy_low", busy, 0);
      checkState("glitch");

      // Framing error followed by a clean frame.
      applyStimulus(8'h3C, 1'b0, 1'b1);
      checkState("framing");
      applyStimulus(8'h11, 1'b1, 1'b1);
      checkState("after_framing");

      // Backpressure and overrun.
      doReset();
      setReady(1'b0);
      applyStimulus(8'h01, 1'b1, 1'b1);
      applyStimulus(8'h02, 1'b1, 1'b1);
      checkState("overrun_hold");
      setReady(1'b1);
      checkState("overrun_release");

      // Done flag and counter saturation.
      doReset();
      setReady(1'b1);
      applyStimulus(8'h10, 1'b1, 1'b1);
      applyStimulus(8'h20, 1'b1, 1'b1);
      checkOutput("done_before", done, 0);
      applyStimulus(8'h30, 1'b1, 1'b1);
      checkState("done_third");
      applyStimulus(8'h40, 1'b1, 1'b1);
      checkState("saturate");

      // Reset taken during data bit 4 aborts the frame quietly.
      d = 8'h5A;
      rx = 1'b0;
      waitClocks(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         waitClocks(CPB);
      end
      rx = d[4];
      waitClocks(CPB / 2);
      rst = 1'b1;
      rx = 1'b1;
      waitClocks(1);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_m_valid", m_valid, 0);
      checkOutput("midrst_byte_count", byte_count, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_errs", {frame_err, parity_err, overrun_err}, 0);
      rst = 1'b0;
      modelReset();
      waitClocks(2 * CPB);
      applyStimulus(8'h7E, 1'b1, 1'b1);
      checkState("after_midrst");

`ifdef UART_RX_PARITY_EN
      // Wrong even-parity bit drops the word without a framing error.
      applyStimulus(8'h07, 1'b1, 1'b0);
      checkState("parity");
`endif

      // Randomized frames with random readiness and occasional bad stop/parity bits.
      doReset();
      for (int n = 0; n < 16; n++) begin
         setReady(1'($urandom_range(0, 1)));
         d = 8'($urandom);
         applyStimulus(d, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
         checkState("rand");
      end
      setReady(1'b1);
      checkState("rand_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
